branch_predictor: RTL and testbench

Dynamic branch predictor and mispredict controller for the 5-stage RISC-V pipeline. It predicts conditional branches at fetch from a direct-mapped BTB. Each BTB entry holds a 2-bit saturating counter. In EX it compares the prediction against the resolved outcome (BranchE and branch target) and updates the tables. On a mismatch it raises a mispredict with the corrected PC, which the hazard unit uses to flush IF/ID. It also keeps branch and mispredict counters for CPI experiments.

---
 rtl/branch_predictor_pkg.sv | 27 ++
 rtl/branch_predictor_btb_table.sv | 61 ++++++
 rtl/branch_predictor.sv | 81 ++++++++
 tb/tb_branch_predictor.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared branch-type codes and 2-bit saturating counter encodings for the
// fetch predictor and its BTB.
package branch_predictor_pkg;

    typedef enum logic [2:0] {
        NOBRANCH = 3'd0,
        BEQ      = 3'd1,
        BNE      = 3'd2,
        BLT      = 3'd3,
        BGE      = 3'd4,
        BLTU     = 3'd5,
        BGEU     = 3'd6
    } branch_type_e;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        if (taken) return (c == ST)  ? ST  : c + 2'd1;
        else       return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_btb_table.sv
// Direct-mapped BTB storage: combinational lookup port, one synchronous
// update port. Only the valid bits are reset; tag/target/ctr are don't-care.
module btb_table
    import branch_predictor_pkg::*;
#(
    parameter int ENTRY_BITS = 6,
    parameter int PC_W       = 32,
    localparam int TAG_W     = PC_W - ENTRY_BITS - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ENTRY_BITS-1:0] lookup_idx,
    input  logic [TAG_W-1:0]      lookup_tag,
    output logic                  lookup_hit,
    output logic [1:0]            lookup_ctr,
    output logic [PC_W-1:0]       lookup_target,
    input  logic                  upd_en,
    input  logic [ENTRY_BITS-1:0] upd_idx,
    input  logic [TAG_W-1:0]      upd_tag,
    input  logic                  upd_taken,
    input  logic [PC_W-1:0]       upd_target,
    input  logic                  inval_en
);
    localparam int N = 1 << ENTRY_BITS;

    logic [N-1:0]     valid;
    logic [TAG_W-1:0] tags    [N];
    logic [PC_W-1:0]  targets [N];
    logic [1:0]       ctrs    [N];
    logic             upd_hit;

    assign lookup_hit    = valid[lookup_idx] && (tags[lookup_idx] == lookup_tag);
    assign lookup_ctr    = ctrs[lookup_idx];
    assign lookup_target = targets[lookup_idx];
    assign upd_hit       = valid[upd_idx] && (tags[upd_idx] == upd_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (upd_en && upd_taken && !upd_hit) begin
            valid[upd_idx] <= 1'b1;
        end else if (inval_en && upd_hit) begin
            valid[upd_idx] <= 1'b0;
        end
    end

    // A taken miss replaces whatever occupies the slot, aliased or not.
    always_ff @(posedge clk) begin
        if (upd_en) begin
            if (upd_hit) begin
                ctrs[upd_idx] <= ctr_next(ctrs[upd_idx], upd_taken);
                if (upd_taken) targets[upd_idx] <= upd_target;
            end else if (upd_taken) begin
                tags[upd_idx]    <= upd_tag;
                targets[upd_idx] <= upd_target;
                ctrs[upd_idx]    <= WT;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-time branch prediction, EX-stage mispredict detection/redirect and
// branch/mispredict statistics for the 5-stage pipeline.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRY_BITS = 6,
    parameter int PC_W       = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] PCF,
    output logic            PredTakenF,
    output logic [PC_W-1:0] PredTargetF,
    input  logic [PC_W-1:0] PCE,
    input  logic [2:0]      BranchTypeE,
    input  logic            BranchE,
    input  logic [PC_W-1:0] BrTargetE,
    input  logic            PredTakenE,
    input  logic [PC_W-1:0] PredTargetE,
    input  logic            StallE,
    output logic            MispredE,
    output logic [PC_W-1:0] RedirectPCE,
    output logic [31:0]     BranchCnt,
    output logic [31:0]     MissCnt
);
    localparam int TAG_W = PC_W - ENTRY_BITS - 2;

    logic            hit;
    logic [1:0]      ctr;
    logic [PC_W-1:0] target;
    logic            resolve;
    logic            is_br;

    assign resolve = !StallE;
    assign is_br   = (BranchTypeE != NOBRANCH);

    btb_table #(.ENTRY_BITS(ENTRY_BITS), .PC_W(PC_W)) u_btb (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_idx    (PCF[ENTRY_BITS+1:2]),
        .lookup_tag    (PCF[PC_W-1:ENTRY_BITS+2]),
        .lookup_hit    (hit),
        .lookup_ctr    (ctr),
        .lookup_target (target),
        .upd_en        (resolve && is_br),
        .upd_idx       (PCE[ENTRY_BITS+1:2]),
        .upd_tag       (PCE[PC_W-1:ENTRY_BITS+2]),
        .upd_taken     (BranchE),
        .upd_target    (BrTargetE),
        .inval_en      (resolve && !is_br && PredTakenE)
    );

    assign PredTakenF  = hit && ctr[1];
    assign PredTargetF = PredTakenF ? target : PCF + PC_W'(4);

    // rst_n gates MispredE so a flush is never requested while in reset.
    always_comb begin
        MispredE    = 1'b0;
        RedirectPCE = PCE + PC_W'(4);
        if (resolve && rst_n) begin
            if (is_br) begin
                MispredE = (BranchE != PredTakenE) ||
                           (BranchE && PredTakenE && (PredTargetE != BrTargetE));
                if (BranchE) RedirectPCE = BrTargetE;
            end else if (PredTakenE) begin
                MispredE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BranchCnt <= '0;
            MissCnt   <= '0;
        end else if (resolve) begin
            if (is_br)    BranchCnt <= BranchCnt + 32'd1;
            if (MispredE) MissCnt   <= MissCnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expectations are queued as each step is
// driven and drained against the DUT outputs at the sample point.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] PCF, PredTargetF, PCE, BrTargetE, PredTargetE, RedirectPCE;
    logic [31:0] BranchCnt, MissCnt;
    logic [2:0]  BranchTypeE;
    logic        PredTakenF, BranchE, PredTakenE, StallE, MispredE;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    branch_predictor #(.ENTRY_BITS(6), .PC_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCF         (PCF),
        .PredTakenF  (PredTakenF),
        .PredTargetF (PredTargetF),
        .PCE         (PCE),
        .BranchTypeE (BranchTypeE),
        .BranchE     (BranchE),
        .BrTargetE   (BrTargetE),
        .PredTakenE  (PredTakenE),
        .PredTargetE (PredTargetE),
        .StallE      (StallE),
        .MispredE    (MispredE),
        .RedirectPCE (RedirectPCE),
        .BranchCnt   (BranchCnt),
        .MissCnt     (MissCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] obs(input string t);
        case (t)
            "pt":   return {31'b0, PredTakenF};
            "ptgt": return PredTargetF;
            "mis":  return {31'b0, MispredE};
            "rpc":  return RedirectPCE;
            "bc":   return BranchCnt;
            "mc":   return MissCnt;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] got;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = obs(e.tag);
            total++;
            assert (got === e.val) else begin
                bad++;
                $error("FAIL %s got=%h exp=%h", e.tag, got, e.val);
            end
        end
    endtask

    task automatic ex(input logic [2:0] ty, input logic [31:0] pce, input logic br,
                      input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        BranchTypeE = ty;
        PCE         = pce;
        BranchE     = br;
        BrTargetE   = tgt;
        PredTakenE  = pt;
        PredTargetE = ptgt;
    endtask

    task automatic idle();
        ex(NOBRANCH, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        StallE = 1'b0;
    endtask

    task automatic counters(input logic [31:0] bc, input logic [31:0] mc);
        @(posedge clk); #1;
        push("bc", bc); push("mc", mc);
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        PCF   = 32'h100;
        idle();
        PCE   = 32'h40;
        #2;
        push("pt", 0); push("ptgt", 32'h104); push("mis", 0);
        push("rpc", 32'h44); push("bc", 0); push("mc", 0);
        drain();
        @(negedge clk) rst_n = 1'b1;

        // cold miss: BNE taken, predicted not taken
        @(negedge clk);
        PCF = 32'h100;
        ex(BNE, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        #2;
        push("pt", 0); push("ptgt", 32'h104); push("mis", 1); push("rpc", 32'h80);
        drain();
        counters(1, 1);

        // hit with ctr=10, correct taken prediction -> ctr=11
        @(negedge clk);
        ex(BNE, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        #2;
        push("pt", 1); push("ptgt", 32'h80); push("mis", 0);
        drain();
        counters(2, 1);

        // two not-taken resolutions: 11 -> 10 -> 01
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ex(BNE, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
            #2;
            push("pt", 1); push("mis", 1); push("rpc", 32'h104);
            drain();
            counters(3 + i, 2 + i);
        end

        // ctr=01 predicts not taken; wrong-target resolution retargets
        @(negedge clk);
        ex(BNE, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
        #2;
        push("pt", 0); push("ptgt", 32'h104); push("mis", 1); push("rpc", 32'h90);
        drain();
        counters(5, 4);
        @(negedge clk);
        idle();
        #2;
        push("pt", 1); push("ptgt", 32'h90); push("mis", 0); push("rpc", 32'h104);
        drain();

        // alias 0x200 evicts 0x100 (same index)
        @(negedge clk);
        PCF = 32'h200;
        ex(BEQ, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
        #2;
        push("pt", 0); push("ptgt", 32'h204); push("mis", 1); push("rpc", 32'h300);
        drain();
        counters(6, 5);
        @(negedge clk);
        idle();
        PCF = 32'h100;
        #1;
        push("pt", 0); push("ptgt", 32'h104);
        drain();
        PCF = 32'h200;
        #1;
        push("pt", 1); push("ptgt", 32'h300);
        drain();

        // stalled branch resolves exactly once
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ex(BEQ, 32'h200, 1'b0, 32'h300, 1'b1, 32'h300);
            StallE = 1'b1;
            #2;
            push("mis", 0); push("rpc", 32'h204);
            drain();
            counters(6, 5);
        end
        @(negedge clk);
        StallE = 1'b0;
        #2;
        push("mis", 1); push("rpc", 32'h204);
        drain();
        counters(7, 6);
        @(negedge clk);
        idle();
        #2;
        push("pt", 0); push("ptgt", 32'h204);
        drain();

        // stale entry: NOBRANCH predicted taken invalidates the entry
        @(negedge clk);
        ex(BEQ, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
        #2;
        push("mis", 1); push("rpc", 32'h300);
        drain();
        counters(8, 7);
        @(negedge clk);
        idle();
        #2;
        push("pt", 1); push("ptgt", 32'h300);
        drain();
        @(negedge clk);
        ex(NOBRANCH, 32'h200, 1'b0, 32'h0, 1'b1, 32'h300);
        #2;
        push("mis", 1); push("rpc", 32'h204);
        drain();
        counters(8, 8);
        @(negedge clk);
        idle();
        #2;
        push("pt", 0); push("ptgt", 32'h204);
        drain();

        // reset during a mispredicting cycle
        @(negedge clk);
        ex(BNE, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
        #2;
        push("mis", 1);
        drain();
        #1 rst_n = 1'b0;
        #1;
        push("mis", 0); push("bc", 0); push("mc", 0); push("pt", 0); push("ptgt", 32'h204);
        drain();
        counters(0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        #2;
        push("pt", 0); push("ptgt", 32'h204); push("mis", 0);
        drain();
        PCF = 32'h100;
        #1;
        push("pt", 0); push("ptgt", 32'h104);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
